// File: rtl/acionador_motores.sv
// Actuator sequencer for the cleaning robot: turns level commands into guarded,
// timed, non-overlapping drive sequences on both motors and the debris arm.
module acionador_motores #(
   parameter int PASSO_CICLOS  = 4,
   parameter int GIRO_CICLOS   = 8,
   parameter int BRACO_CICLOS  = 6,
   parameter int GUARDA_CICLOS = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       avancar,
   input  logic       girar,
   input  logic       remover,
   output logic [1:0] mot_esq,
   output logic [1:0] mot_dir,
   output logic       braco_estende,
   output logic       braco_recolhe,
   output logic       ocupado,
   output logic       concluido
);

   localparam logic [7:0] PASSO_M1  = 8'(PASSO_CICLOS - 1);
   localparam logic [7:0] GIRO_M1   = 8'(GIRO_CICLOS - 1);
   localparam logic [7:0] BRACO_M1  = 8'(BRACO_CICLOS - 1);
   localparam logic [7:0] GUARDA_M1 = 8'(GUARDA_CICLOS - 1);

   localparam logic [1:0] MOT_PARA = 2'b00;
   localparam logic [1:0] MOT_FRE  = 2'b01;
   localparam logic [1:0] MOT_RE   = 2'b10;

   typedef enum logic [2:0] {
      OCIOSO, GUARDA, ANDA, CURVA, GIRA, BRACO_EST, BRACO_REC
   } estado_t;

   typedef enum logic [1:0] {
      OP_ANDA, OP_CURVA, OP_GIRA, OP_BRACO
   } op_t;

   estado_t    estado_q, estado_d;
   op_t        op_q, op_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] esq_q, esq_d, dir_q, dir_d;
   logic       est_q, est_d, rec_q, rec_d, ocu_q, ocu_d, con_q, con_d;
   logic       fim;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= OCIOSO;
         op_q     <= OP_ANDA;
         cnt_q    <= 8'd0;
         esq_q    <= MOT_PARA;
         dir_q    <= MOT_PARA;
         est_q    <= 1'b0;
         rec_q    <= 1'b0;
         ocu_q    <= 1'b0;
         con_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         esq_q    <= esq_d;
         dir_q    <= dir_d;
         est_q    <= est_d;
         rec_q    <= rec_d;
         ocu_q    <= ocu_d;
         con_q    <= con_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      fim      = (cnt_q == 8'd0);

      case (estado_q)
         OCIOSO: begin
            if (remover || avancar || girar) begin
               estado_d = GUARDA;
               cnt_d    = GUARDA_M1;
               if (remover)              op_d = OP_BRACO;
               else if (avancar && girar) op_d = OP_CURVA;
               else if (girar)            op_d = OP_GIRA;
               else                       op_d = OP_ANDA;
            end
         end
         GUARDA: begin
            if (fim) begin
               case (op_q)
                  OP_ANDA:  begin estado_d = ANDA;      cnt_d = PASSO_M1; end
                  OP_CURVA: begin estado_d = CURVA;     cnt_d = PASSO_M1; end
                  OP_GIRA:  begin estado_d = GIRA;      cnt_d = GIRO_M1;  end
                  default:  begin estado_d = BRACO_EST; cnt_d = BRACO_M1; end
               endcase
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         BRACO_EST: begin
            if (fim) begin
               estado_d = BRACO_REC;
               cnt_d    = BRACO_M1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ANDA, CURVA, GIRA, BRACO_REC: begin
            if (fim) estado_d = OCIOSO;
            else     cnt_d    = cnt_q - 8'd1;
         end
         default: begin
            estado_d = OCIOSO;
            cnt_d    = 8'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so each output
   // register holds the Moore value of the state being entered.
   always_comb begin
      esq_d = MOT_PARA;
      dir_d = MOT_PARA;
      est_d = 1'b0;
      rec_d = 1'b0;
      ocu_d = (estado_d != OCIOSO);
      con_d = (estado_d == OCIOSO) &&
              ((estado_q == ANDA) || (estado_q == CURVA) ||
               (estado_q == GIRA) || (estado_q == BRACO_REC));
      case (estado_d)
         ANDA:      begin esq_d = MOT_FRE; dir_d = MOT_FRE;  end
         CURVA:     begin esq_d = MOT_FRE; dir_d = MOT_PARA; end
         GIRA:      begin esq_d = MOT_FRE; dir_d = MOT_RE;   end
         BRACO_EST: est_d = 1'b1;
         BRACO_REC: rec_d = 1'b1;
         default:   ;
      endcase
   end

   assign mot_esq       = esq_q;
   assign mot_dir       = dir_q;
   assign braco_estende = est_q;
   assign braco_recolhe = rec_q;
   assign ocupado       = ocu_q;
   assign concluido     = con_q;

endmodule

// File: tb/tb_acionador_motores.sv
// Directed bench for acionador_motores with default timing parameters.
module tb_acionador_motores;

   logic       clock, reset, avancar, girar, remover;
   logic [1:0] mot_esq, mot_dir;
   logic       braco_estende, braco_recolhe, ocupado, concluido;

   int n_asserts = 0;
   int n_fails   = 0;

   // Packed view: {mot_esq, mot_dir, estende, recolhe, ocupado, concluido}
   localparam logic [7:0] V_IDLE  = 8'b00_00_0_0_0_0;
   localparam logic [7:0] V_GUARD = 8'b00_00_0_0_1_0;
   localparam logic [7:0] V_ANDA  = 8'b01_01_0_0_1_0;
   localparam logic [7:0] V_CURVA = 8'b01_00_0_0_1_0;
   localparam logic [7:0] V_GIRA  = 8'b01_10_0_0_1_0;
   localparam logic [7:0] V_EST   = 8'b00_00_1_0_1_0;
   localparam logic [7:0] V_REC   = 8'b00_00_0_1_1_0;
   localparam logic [7:0] V_DONE  = 8'b00_00_0_0_0_1;

   acionador_motores dut (
      .clock         (clock),
      .reset         (reset),
      .avancar       (avancar),
      .girar         (girar),
      .remover       (remover),
      .mot_esq       (mot_esq),
      .mot_dir       (mot_dir),
      .braco_estende (braco_estende),
      .braco_recolhe (braco_recolhe),
      .ocupado       (ocupado),
      .concluido     (concluido)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] exp_v);
      logic [7:0] obs;
      obs = {mot_esq, mot_dir, braco_estende, braco_recolhe, ocupado, concluido};
      n_asserts++;
      assert (obs === exp_v) else begin
         n_fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   task automatic run_cycles(input string tag, input logic [7:0] exp_v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk(tag, exp_v);
      end
   endtask

   // Issue a command from idle for one acceptance edge, then check the whole sequence.
   task automatic run_op(input string tag, input logic av, input logic gi, input logic re,
                         input logic [7:0] v1, input int n1,
                         input logic [7:0] v2, input int n2);
      avancar = av; girar = gi; remover = re;
      @(negedge clock);
      chk({tag, "_guard1"}, V_GUARD);
      avancar = 1'b0; girar = 1'b0; remover = 1'b0;
      run_cycles({tag, "_guard2"}, V_GUARD, 1);
      run_cycles({tag, "_op1"}, v1, n1);
      if (n2 > 0) run_cycles({tag, "_op2"}, v2, n2);
      run_cycles({tag, "_done"}, V_DONE, 1);
      run_cycles({tag, "_idle"}, V_IDLE, 1);
   endtask

   initial begin
      reset = 1'b0; avancar = 1'b0; girar = 1'b0; remover = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset_state", V_IDLE);
      reset = 1'b1;
      run_cycles("idle_no_cmd", V_IDLE, 2);

      run_op("step",  1'b1, 1'b0, 1'b0, V_ANDA,  4, V_IDLE, 0);
      run_op("spin",  1'b0, 1'b1, 1'b0, V_GIRA,  8, V_IDLE, 0);
      run_op("arc",   1'b1, 1'b1, 1'b0, V_CURVA, 4, V_IDLE, 0);
      run_op("arm",   1'b1, 1'b1, 1'b1, V_EST,   6, V_REC,  6);
      run_op("arm_only", 1'b0, 1'b0, 1'b1, V_EST, 6, V_REC, 6);

      // girar raised during a STEP is neither executed nor queued
      avancar = 1'b1;
      @(negedge clock);
      chk("ign_guard1", V_GUARD);
      avancar = 1'b0;
      @(negedge clock);
      chk("ign_guard2", V_GUARD);
      girar = 1'b1;
      run_cycles("ign_anda_a", V_ANDA, 3);
      girar = 1'b0;
      run_cycles("ign_anda_b", V_ANDA, 1);
      run_cycles("ign_done", V_DONE, 1);
      run_cycles("ign_idle", V_IDLE, 3);

      // avancar held high: 7-cycle repeating pattern
      avancar = 1'b1;
      for (int p = 0; p < 3; p++) begin
         run_cycles("rep_guard", V_GUARD, 2);
         run_cycles("rep_anda",  V_ANDA,  4);
         run_cycles("rep_done",  V_DONE,  1);
      end
      avancar = 1'b0;
      run_cycles("rep_idle", V_IDLE, 2);

      // Asynchronous reset in cycle 5 of a SPIN
      girar = 1'b1;
      @(negedge clock);
      chk("abort_guard1", V_GUARD);
      girar = 1'b0;
      run_cycles("abort_guard2", V_GUARD, 1);
      run_cycles("abort_gira", V_GIRA, 3);
      #1 reset = 1'b0;
      #1 chk("abort_async", V_IDLE);
      @(negedge clock);
      chk("abort_held", V_IDLE);
      reset = 1'b1;
      run_cycles("abort_after", V_IDLE, 3);

      // Back to normal operation after the abort
      run_op("post_abort", 1'b1, 1'b0, 1'b0, V_ANDA, 4, V_IDLE, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
